// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int CLKS_PER_BIT_115200 = 434;

    // Command-word characters consumed by the downstream detector
    localparam logic [7:0] ASCII_S = 8'h53;
    localparam logic [7:0] ASCII_T = 8'h54;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_R = 8'h52;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RX pin metastability synchronizer with falling-edge detect
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_prev;

    // Preset to the idle-high level so reset never looks like a start bit
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign fall_pulse = rxs_prev & ~rxs;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; UART_RX_PARITY_EN adds an even-parity bit and parity_err
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_complete,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic rxs;
    logic fall_pulse;

    rx_state_t     state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_q, shift_n;
    logic [7:0]    msg_n;
    logic          complete_n;
    logic          ferr_n;
    logic          baud_tick;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
    logic perr_n;
`endif

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .rx        (rx),
        .rxs       (rxs),
        .fall_pulse(fall_pulse)
    );

    assign baud_tick = (baud_cnt == LAST_CNT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            rx_msg      <= 8'h00;
            rx_complete <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_cnt_n;
            bit_idx     <= bit_idx_n;
            shift_q     <= shift_n;
            rx_msg      <= msg_n;
            rx_complete <= complete_n;
            frame_err   <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad     <= par_bad_n;
            parity_err  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift_q;
        msg_n      = rx_msg;
        complete_n = 1'b0;
        ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        perr_n     = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                baud_cnt_n = '0;
                bit_idx_n  = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_n  = 1'b0;
`endif
                if (fall_pulse) begin
                    state_n = START;
                end
            end
            // Half-bit wait re-checks the start bit to reject short glitches
            START: begin
                if (baud_cnt == HALF_CNT) begin
                    baud_cnt_n = '0;
                    state_n    = rxs ? IDLE : DATA;
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_cnt_n       = '0;
                    shift_n[bit_idx] = rxs;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    baud_cnt_n = '0;
                    par_bad_n  = (^shift_q) ^ rxs;
                    state_n    = STOP;
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
`endif
            // A low stop bit wins over a parity error
            STOP: begin
                if (baud_tick) begin
                    baud_cnt_n = '0;
                    if (rxs) begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            perr_n = 1'b1;
                        end else begin
                            msg_n      = shift_q;
                            complete_n = 1'b1;
                        end
`else
                        msg_n      = shift_q;
                        complete_n = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            BREAK: begin
                baud_cnt_n = '0;
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
